// File: rtl/muu_unit.sv
// muu_unit: HI/LO owner with a 32-step sequential multiplier/divider and MUL write-back
module muu_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        special2,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] result,
  output logic        write_en,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {OP_MULT, OP_MADD, OP_MSUB, OP_MUL, OP_DIV} op_t;
  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] r_q, r_d;
  logic [31:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d, res_q, res_d;
  logic        negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;
  logic is_mfhi, is_mflo, is_mthi, is_mtlo, is_mult, is_multu, is_div, is_divu;
  logic is_madd, is_msubu, is_mul, is_iter, is_muu, signed_op;
  logic [31:0] a_mag, b_mag, quo, rem;
  logic [32:0] mul_sum, div_top, div_diff;
  logic [63:0] mul_step, div_step, step, prod, acc;
  assign is_mfhi   = !special2 && funct == 6'b010000;
  assign is_mthi   = !special2 && funct == 6'b010001;
  assign is_mflo   = !special2 && funct == 6'b010010;
  assign is_mtlo   = !special2 && funct == 6'b010011;
  assign is_mult   = !special2 && funct == 6'b011000;
  assign is_multu  = !special2 && funct == 6'b011001;
  assign is_div    = !special2 && funct == 6'b011010;
  assign is_divu   = !special2 && funct == 6'b011011;
  assign is_madd   = special2 && funct == 6'b000000;
  assign is_mul    = special2 && funct == 6'b000010;
  assign is_msubu  = special2 && funct == 6'b000101;
  assign is_iter   = is_mult | is_multu | is_div | is_divu | is_madd | is_msubu | is_mul;
  assign is_muu    = is_iter | is_mfhi | is_mflo | is_mthi | is_mtlo;
  assign signed_op = is_mult | is_div | is_madd | is_mul;
  assign a_mag = (signed_op && rs_data[31]) ? -rs_data : rs_data;
  assign b_mag = (signed_op && rt_data[31]) ? -rt_data : rt_data;
  // r_q holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign mul_sum  = {1'b0, r_q[63:32]} + (r_q[0] ? {1'b0, m_q} : 33'd0);
  assign mul_step = {mul_sum, r_q[31:1]};
  assign div_top  = r_q[63:31];
  assign div_diff = div_top - {1'b0, m_q};
  assign div_step = {div_diff[32] ? div_top[31:0] : div_diff[31:0], r_q[30:0], !div_diff[32]};
  assign step = (op_q == OP_DIV) ? div_step : mul_step;
  assign prod = negq_q ? -step : step;
  assign acc  = ((op_q == OP_MULT) ? 64'd0 : {hi_q, lo_q}) + ((op_q == OP_MSUB) ? -prod : prod);
  // divide-by-zero quotient is forced; the remainder path already yields rs
  assign quo  = dz_q ? 32'hFFFF_FFFF : (negq_q ? -step[31:0] : step[31:0]);
  assign rem  = negr_q ? -step[63:32] : step[63:32];
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    m_d     = m_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (start) begin
        hi_d = is_mthi ? rs_data : hi_q;
        lo_d = is_mtlo ? rs_data : lo_q;
        if (is_iter) begin
          state_d = RUN;
          cnt_d   = 5'd0;
          op_d    = is_mul ? OP_MUL : is_madd ? OP_MADD : is_msubu ? OP_MSUB :
                    (is_div | is_divu) ? OP_DIV : OP_MULT;
          r_d     = {32'd0, a_mag};
          m_d     = b_mag;
          negq_d  = signed_op && (rs_data[31] ^ rt_data[31]);
          negr_d  = signed_op && rs_data[31];
          dz_d    = rt_data == 32'd0;
        end
      end
      RUN: begin
        r_d   = step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = (op_q == OP_MUL) ? DONE : IDLE;
          hi_d    = (op_q == OP_DIV) ? rem : (op_q == OP_MUL) ? hi_q : acc[63:32];
          lo_d    = (op_q == OP_DIV) ? quo : (op_q == OP_MUL) ? lo_q : acc[31:0];
          res_d   = (op_q == OP_MUL) ? prod[31:0] : res_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= 5'd0;
      r_q     <= 64'd0;
      m_q     <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      m_q     <= m_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
    end
  end
  assign busy     = state_q == RUN;
  assign stall    = start && ((state_q == RUN && is_muu) || (state_q == IDLE && is_mul));
  assign write_en = state_q == DONE || (state_q == IDLE && start && (is_mfhi || is_mflo));
  assign result   = (state_q == DONE) ? res_q :
                    (state_q == IDLE && start && is_mfhi) ? hi_q :
                    (state_q == IDLE && start && is_mflo) ? lo_q : 32'd0;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_muu_unit.sv
// tb_muu_unit: directed vectors with a scoreboard popped on write-back and on busy falling
module tb_muu_unit;
  logic        clk = 1'b0;
  logic        rst_n, start, special2;
  logic [5:0]  funct;
  logic [31:0] rs_data, rt_data, result, hi, lo;
  logic        write_en, stall, busy;
  logic        busy_p = 1'b0;
  int tests = 0;
  int errs  = 0;
  int n;
  typedef struct {
    bit          hl;
    logic [31:0] a;
    logic [31:0] b;
    string       name;
  } exp_t;
  exp_t q[$];
  exp_t e;

  muu_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .special2(special2), .funct(funct),
    .rs_data(rs_data), .rt_data(rt_data), .result(result), .write_en(write_en),
    .stall(stall), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy_p && !busy) begin
      tests++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL unexpected hi/lo update: hi=%h lo=%h", hi, lo);
      end else begin
        e = q.pop_front();
        if (!e.hl || hi !== e.a || lo !== e.b) begin
          errs++;
          $display("FAIL %s: got hi=%h lo=%h, want hi=%h lo=%h (hl=%0d)", e.name, hi, lo, e.a, e.b, e.hl);
        end
      end
    end
    if (write_en === 1'b1) begin
      tests++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL unexpected write: result=%h", result);
      end else begin
        e = q.pop_front();
        if (e.hl || result !== e.a) begin
          errs++;
          $display("FAIL %s: got result=%h, want %h (hl=%0d)", e.name, result, e.a, e.hl);
        end
      end
    end
    busy_p <= busy;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic drive(input bit s, input bit sp, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    start = s; special2 = sp; funct = f; rs_data = a; rt_data = b;
  endtask

  task automatic rd(input logic [5:0] f, input logic [31:0] exp, input string name);
    q.push_back('{1'b0, exp, 32'd0, name});
    drive(1'b1, 1'b0, f, 32'd0, 32'd0);
  endtask

  task automatic iter(input bit sp, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] hi_e, input logic [31:0] lo_e, input string name);
    int cnt;
    q.push_back('{1'b1, hi_e, lo_e, name});
    drive(1'b1, sp, f, a, b);
    drive(1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    chk({name, " busy cycles"}, cnt, 32);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; special2 = 1'b0; funct = 6'd0; rs_data = 32'd0; rt_data = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset write_en", {31'd0, write_en}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    drive(1'b1, 1'b0, 6'b010001, 32'h1234_5678, 32'd0);
    drive(1'b1, 1'b0, 6'b010011, 32'h9ABC_DEF0, 32'd0);
    rd(6'b010000, 32'h1234_5678, "mfhi");
    rd(6'b010010, 32'h9ABC_DEF0, "mflo");
    drive(1'b1, 1'b0, 6'b010001, 32'hAAAA_5555, 32'd0);
    @(posedge clk); #1 rst_n = 1'b0; start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    rd(6'b010000, 32'd0, "mfhi after reset");
    rd(6'b010010, 32'd0, "mflo after reset");
    drive(1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
    iter(1'b0, 6'b011000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult -2*3");
    iter(1'b0, 6'b011001, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
    iter(1'b0, 6'b011010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2");
    iter(1'b0, 6'b011011, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, "divu 7/0");
    iter(1'b0, 6'b011010, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div -7/0");
    iter(1'b0, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div min/-1");
    q.push_back('{1'b1, 32'd0, 32'h8000_0000, "mul keeps hi/lo"});
    q.push_back('{1'b0, 32'hFFFF_F448, 32'd0, "mul result"});
    drive(1'b1, 1'b1, 6'b000010, 32'd1000, 32'hFFFF_FFFD);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    chk("mul stall cycles", n, 33);
    drive(1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("mul no relaunch", {31'd0, busy}, 32'd0);
    chk("mul single write", {31'd0, write_en}, 32'd0);
    drive(1'b1, 1'b0, 6'b010001, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 6'b010011, 32'hFFFF_FFFF, 32'd0);
    iter(1'b1, 6'b000000, 32'd1, 32'd1, 32'd1, 32'd0, "madd 1*1");
    iter(1'b1, 6'b000101, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, "msubu 1*1");
    iter(1'b1, 6'b000000, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFE, "madd -1*1");
    q.push_back('{1'b1, 32'd0, 32'd0, "reset aborts run"});
    drive(1'b1, 1'b0, 6'b011000, 32'd5, 32'd5);
    repeat (3) drive(1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort busy", {31'd0, busy}, 32'd0);
    q.push_back('{1'b1, 32'd0, 32'h0012_3450, "mult before mflo"});
    q.push_back('{1'b0, 32'h0012_3450, 32'd0, "interlocked mflo"});
    drive(1'b1, 1'b0, 6'b011000, 32'h0001_2345, 32'h10);
    drive(1'b1, 1'b0, 6'b010010, 32'd0, 32'd0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    chk("mflo interlock cycles", n, 32);
    drive(1'b1, 1'b0, 6'b111111, 32'hDEAD_BEEF, 32'hBEEF);
    @(negedge clk);
    chk("unknown write_en", {31'd0, write_en}, 32'd0);
    chk("unknown stall", {31'd0, stall}, 32'd0);
    drive(1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("unknown busy", {31'd0, busy}, 32'd0);
    chk("unknown hi", hi, 32'd0);
    chk("unknown lo", lo, 32'h0012_3450);
    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL scoreboard drain: %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
